// File: rtl/jtkicker_colmix.sv
// rtl/jtkicker_colmix.sv - scroll/object priority mixer, PROM colour lookup, blank-gated RGB
// Optional build macro: JTKICKER_COLMIX_DEBUG_EN adds gfx_en layer masks and debug_idx.
module jtkicker_colmix #(
  parameter bit OBJ_PRIO   = 1'b1,
  parameter bit BLANK_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  input  logic [3:0] scr_pxl,
  input  logic [3:0] obj_pxl,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic [6:0] prog_addr,
  input  logic [3:0] prog_data,
  input  logic       prog_en,
`ifdef JTKICKER_COLMIX_DEBUG_EN
  input  logic [1:0] gfx_en,
  output logic [4:0] debug_idx,
`endif
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  // Layer pixels after optional debug masking
  logic [3:0] w_scr;
  logic [3:0] w_obj;
  logic       w_obj_vis;
  logic [4:0] w_idx;
  logic       w_blank2;

  // S1: colour index and blanking
  logic [4:0] r_idx1;
  logic       r_lhbl1;
  logic       r_lvbl1;

  // S2: PROM read data and blanking
  logic [3:0] r_lut_r;
  logic [3:0] r_lut_g;
  logic [3:0] r_lut_b;
  logic       r_lhbl2;
  logic       r_lvbl2;

  // S3: output registers
  logic [3:0] r_red;
  logic [3:0] r_green;
  logic [3:0] r_blue;
  logic       r_lhbl3;
  logic       r_lvbl3;

  // Colour PROMs, loaded at run time and never cleared by reset
  logic [3:0] r_prom_r [0:31];
  logic [3:0] r_prom_g [0:31];
  logic [3:0] r_prom_b [0:31];

`ifdef JTKICKER_COLMIX_DEBUG_EN
  assign w_scr     = gfx_en[0] ? scr_pxl : 4'd0;
  assign w_obj     = gfx_en[1] ? obj_pxl : 4'd0;
  assign debug_idx = r_idx1;
`else
  assign w_scr = scr_pxl;
  assign w_obj = obj_pxl;
`endif

  assign w_obj_vis = (w_obj != 4'd0);

  // Priority merge: objects sit in the upper half of the palette
  always_comb begin
    w_idx = {1'b0, w_scr};
    if (OBJ_PRIO) begin
      if (w_obj_vis) w_idx = {1'b1, w_obj};
    end else begin
      if (w_obj_vis && (w_scr == 4'd0)) w_idx = {1'b1, w_obj};
    end
  end

  // PROM download path; select 3 is an unused slot and writes nothing
  always_ff @(posedge clk) begin
    if (prog_en) begin
      case (prog_addr[6:5])
        2'd0:    r_prom_r[prog_addr[4:0]] <= prog_data;
        2'd1:    r_prom_g[prog_addr[4:0]] <= prog_data;
        2'd2:    r_prom_b[prog_addr[4:0]] <= prog_data;
        default: ;
      endcase
    end
  end

  // S1 register: latch merged index and raw blanking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx1  <= 5'd0;
      r_lhbl1 <= 1'b0;
      r_lvbl1 <= 1'b0;
    end else if (pxl_cen) begin
      r_idx1  <= w_idx;
      r_lhbl1 <= LHBL;
      r_lvbl1 <= LVBL;
    end
  end

  // S2 register: synchronous PROM read; a same-edge write is seen on the next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lut_r <= 4'd0;
      r_lut_g <= 4'd0;
      r_lut_b <= 4'd0;
      r_lhbl2 <= 1'b0;
      r_lvbl2 <= 1'b0;
    end else if (pxl_cen) begin
      r_lut_r <= r_prom_r[r_idx1];
      r_lut_g <= r_prom_g[r_idx1];
      r_lut_b <= r_prom_b[r_idx1];
      r_lhbl2 <= r_lhbl1;
      r_lvbl2 <= r_lvbl1;
    end
  end

  assign w_blank2 = ~r_lhbl2 | ~r_lvbl2;

  // S3 register: blank-gated colour and blanking aligned with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_red   <= 4'd0;
      r_green <= 4'd0;
      r_blue  <= 4'd0;
      r_lhbl3 <= 1'b0;
      r_lvbl3 <= 1'b0;
    end else if (pxl_cen) begin
      if (BLANK_ZERO && w_blank2) begin
        r_red   <= 4'd0;
        r_green <= 4'd0;
        r_blue  <= 4'd0;
      end else begin
        r_red   <= r_lut_r;
        r_green <= r_lut_g;
        r_blue  <= r_lut_b;
      end
      r_lhbl3 <= r_lhbl2;
      r_lvbl3 <= r_lvbl2;
    end
  end

  assign red      = r_red;
  assign green    = r_green;
  assign blue     = r_blue;
  assign LHBL_dly = r_lhbl3;
  assign LVBL_dly = r_lvbl3;

endmodule

// File: doc/jtkicker_colmix.md
Name: jtkicker_colmix

Overview:
- Final colour stage, directly downstream of the tile-map scroll layer and the sprite layer.
- Merges the 4-bit scroll pixel and the 4-bit object pixel by priority into a 5-bit colour index.
- Looks the index up in three downloadable 32x4 colour PROMs (R, G, B).
- Outputs registered, blank-gated 4-4-4 RGB with blanking signals delayed to match.

Parameters:
- OBJ_PRIO, 1: 1 = any non-transparent object pixel beats scroll; 0 = object shown only where scroll pixel is 0.
- BLANK_ZERO, 1: 1 = RGB forced to 0 while delayed blanking is active; 0 = RGB passes through unmodified.

Ports:
- clk        in   1  system clock (48 MHz)
- rst_n      in   1  asynchronous, active-low reset
- pxl_cen    in   1  pixel clock enable
- scr_pxl    in   4  scroll layer palette output
- obj_pxl    in   4  object layer pixel; 0 = transparent
- LHBL       in   1  horizontal blank, active low
- LVBL       in   1  vertical blank, active low
- prog_addr  in   7  PROM download address: [6:5] PROM select, [4:0] entry
- prog_data  in   4  PROM download data
- prog_en    in   1  PROM write strobe, one clk per write
- red        out  4  red output
- green      out  4  green output
- blue       out  4  blue output
- LHBL_dly   out  1  LHBL aligned with RGB
- LVBL_dly   out  1  LVBL aligned with RGB

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline registers, red/green/blue, LHBL_dly and LVBL_dly go to 0. PROM contents are not cleared.
- Pipeline advances only on clk edges with pxl_cen=1 and holds otherwise. Latency is exactly 3 pxl_cen ticks from inputs to outputs, for both colour and blanking.
- S1, priority: obj_vis = obj_pxl != 0.
  - OBJ_PRIO=1: idx = obj_vis ? {1'b1, obj_pxl} : {1'b0, scr_pxl}.
  - OBJ_PRIO=0: idx = (obj_vis && scr_pxl==0) ? {1'b1, obj_pxl} : {1'b0, scr_pxl}.
  - idx, LHBL and LVBL are registered into S1.
- S2, lookup: three PROMs read at idx1 with registered outputs; the blank bits advance to S2.
- S3, output: rgb <= blank2 ? 0 : prom_q when BLANK_ZERO=1. blank2 = ~LHBL2 | ~LVBL2. The blank bits advance to LHBL_dly/LVBL_dly.
- PROM download:
  - On a clk edge with prog_en=1, the write happens regardless of pxl_cen.
  - prog_addr[6:5]: 0 = red, 1 = green, 2 = blue, 3 = ignored (no write).
  - A write and read to the same entry on the same edge returns the old data; the new data is visible on the next read.
- Reset mid-frame: the pipeline restarts from zeros. The first valid pixel appears 3 pxl_cen ticks after rst_n rises.
- pxl_cen held low: outputs and delayed blanks are frozen at their last values.

Optional Feature:
- Macro: JTKICKER_COLMIX_DEBUG_EN.
- When defined:
  - Extra input gfx_en[1:0]. gfx_en[0]=0 forces scr_pxl to be treated as 0; gfx_en[1]=0 forces obj_pxl to be treated as 0. The mask is applied before S1.
  - Extra output debug_idx[4:0] = S1 idx register.
- When undefined: neither port exists and both layers are always enabled.

Test Plan:
- PROM load and readback: write red[0x05]=0xA, green[0x05]=0x5, blue[0x05]=0xF; drive scr_pxl=5, obj_pxl=0, blanks high -> after 3 pxl_cen ticks rgb = A/5/F.
- Priority: set red[0x13]=0x3, red[0x04]=0x9.
  - OBJ_PRIO=1, scr=4, obj=3 -> red=3.
  - OBJ_PRIO=0, same inputs -> red=9.
  - OBJ_PRIO=0, scr=0, obj=3 -> red=3.
- Blanking: drop LHBL for 10 pxl_cen ticks with non-zero pixels -> LHBL_dly low exactly 3 ticks later for 10 ticks, with rgb=0 throughout.
- Write to prog_addr[6:5]=3 (addr 0x65, data 0xF) -> red/green/blue entries 5 unchanged on readback.
- Reset mid-line: assert rst_n=0 while rgb=A/5/F -> outputs 0 immediately; after release, valid colour after 3 pxl_cen ticks.
- pxl_cen stall: hold pxl_cen=0 for 20 clk while inputs change -> outputs stable; resume -> correct sequence with no dropped or duplicated pixel.
